// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and edge-conditions the raw
// push buttons of the tic-tac-toe board. Each channel yields a clean level
// (btn_db), a one-cycle press pulse (btn_scen) and a press-plus-auto-repeat
// pulse (btn_mcen). Channels are independent; all outputs are registered.
module button_conditioner #(
    parameter int N_BTN       = 5,
    parameter int CNT_W       = 27,
    parameter int DBNC_CYCLES = 1_000_000,
    parameter int RPT_DELAY   = 50_000_000,
    parameter int RPT_PERIOD  = 10_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_scen,
    output logic [N_BTN-1:0] btn_mcen
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DBNC_C  = CNT_W'(DBNC_CYCLES);
    localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(RPT_DELAY);
    localparam logic [CNT_W-1:0] PER_C   = CNT_W'(RPT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // ---- stage p0/p1: two-flop synchroniser on the asynchronous inputs ----
    logic [N_BTN-1:0] sync_p0;
    logic [N_BTN-1:0] sync_p1;

    // Bring the raw buttons into the clk domain before any decision is made.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // ---- stage p2: per-channel debounce / repeat FSM, registered outputs ----
    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] hcnt;
        logic [CNT_W-1:0] pcnt;
        logic             rpt_on;
        logic             db_p2;
        logic             scen_p2;
        logic             mcen_p2;
        logic             s;
        logic [CNT_W-1:0] cnt_inc;
        logic [CNT_W-1:0] hcnt_inc;
        logic [CNT_W-1:0] pcnt_inc;

        assign s        = sync_p1[i];
        assign cnt_inc  = sat_inc(cnt);
        assign hcnt_inc = sat_inc(hcnt);
        assign pcnt_inc = sat_inc(pcnt);

        // Debounce the synchronised level and time the auto-repeat while held;
        // rpt_on separates the initial delay from the periodic phase so the
        // repeat keeps running even after hcnt saturates.
        always_ff @(posedge clk) begin
            if (rst) begin
                state   <= IDLE;
                cnt     <= '0;
                hcnt    <= '0;
                pcnt    <= '0;
                rpt_on  <= 1'b0;
                db_p2   <= 1'b0;
                scen_p2 <= 1'b0;
                mcen_p2 <= 1'b0;
            end else begin
                scen_p2 <= 1'b0;
                mcen_p2 <= 1'b0;
                case (state)
                    IDLE: begin
                        if (s) begin
                            cnt <= CNT_W'(1);
                            if (DBNC_CYCLES == 1) begin
                                state   <= HELD;
                                db_p2   <= 1'b1;
                                scen_p2 <= 1'b1;
                                mcen_p2 <= 1'b1;
                                hcnt    <= '0;
                                pcnt    <= '0;
                                rpt_on  <= 1'b0;
                            end else begin
                                state <= PRESS_WAIT;
                            end
                        end
                    end
                    PRESS_WAIT: begin
                        if (!s) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt_inc == DBNC_C) begin
                            state   <= HELD;
                            cnt     <= cnt_inc;
                            db_p2   <= 1'b1;
                            scen_p2 <= 1'b1;
                            mcen_p2 <= 1'b1;
                            hcnt    <= '0;
                            pcnt    <= '0;
                            rpt_on  <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    HELD: begin
                        if (!s) begin
                            cnt <= CNT_W'(1);
                            if (DBNC_CYCLES == 1) begin
                                state <= IDLE;
                                db_p2 <= 1'b0;
                            end else begin
                                state <= RELEASE_WAIT;
                            end
                        end else begin
                            hcnt <= hcnt_inc;
                            if (RPT_DELAY != 0) begin
                                if (!rpt_on) begin
                                    if (hcnt_inc == DELAY_C) begin
                                        mcen_p2 <= 1'b1;
                                        rpt_on  <= 1'b1;
                                        pcnt    <= '0;
                                    end
                                end else if (pcnt_inc == PER_C) begin
                                    mcen_p2 <= 1'b1;
                                    pcnt    <= '0;
                                end else begin
                                    pcnt <= pcnt_inc;
                                end
                            end
                        end
                    end
                    RELEASE_WAIT: begin
                        if (s) begin
                            state  <= HELD;
                            cnt    <= '0;
                            hcnt   <= '0;
                            pcnt   <= '0;
                            rpt_on <= 1'b0;
                        end else if (cnt_inc == DBNC_C) begin
                            state <= IDLE;
                            cnt   <= '0;
                            db_p2 <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        db_p2 <= 1'b0;
                    end
                endcase
            end
        end

        assign btn_db[i]   = db_p2;
        assign btn_scen[i] = scen_p2;
        assign btn_mcen[i] = mcen_p2;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DBNC_CYCLES=4, RPT_DELAY=10,
// RPT_PERIOD=5, CNT_W=8, plus a second instance with repeat disabled.
module tb_button_conditioner;

    logic       clk;
    logic       rst;
    logic [4:0] btn_raw;
    logic [4:0] btn_db;
    logic [4:0] btn_scen;
    logic [4:0] btn_mcen;
    logic [4:0] raw2;
    logic [4:0] db2;
    logic [4:0] scen2;
    logic [4:0] mcen2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0] raw;
        logic [4:0] db;
        logic [4:0] scen;
        logic [4:0] mcen;
    } vec_t;

    vec_t vecs[$];

    button_conditioner #(
        .N_BTN(5), .CNT_W(8), .DBNC_CYCLES(4), .RPT_DELAY(10), .RPT_PERIOD(5)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_db(btn_db), .btn_scen(btn_scen), .btn_mcen(btn_mcen)
    );

    button_conditioner #(
        .N_BTN(5), .CNT_W(8), .DBNC_CYCLES(4), .RPT_DELAY(0), .RPT_PERIOD(5)
    ) dut_norpt (
        .clk(clk), .rst(rst), .btn_raw(raw2),
        .btn_db(db2), .btn_scen(scen2), .btn_mcen(mcen2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx,
                         input logic [4:0] got, input logic [4:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s[%0d] got=%b want=%b", name, idx, got, want);
        end
    endtask

    task automatic push(input logic [4:0] raw, input logic [4:0] db,
                        input logic [4:0] scen, input logic [4:0] mcen);
        vec_t v;
        v.raw  = raw;
        v.db   = db;
        v.scen = scen;
        v.mcen = mcen;
        vecs.push_back(v);
    endtask

    // advance one rising edge and land on the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int e;
        int n_scen;
        int n_mcen;
        int n_lone;

        // vecs[i]: raw level before edge i+1, expected outputs after edge i+1

        // clean press on channel 3, raw high for edges 1..40
        for (int i = 0; i < 60; i++) begin
            e = i + 1;
            push((i < 40) ? 5'b01000 : 5'b00000,
                 (e >= 6 && e <= 45) ? 5'b01000 : 5'b00000,
                 (e == 6) ? 5'b01000 : 5'b00000,
                 (e inside {6, 16, 21, 26, 31, 36, 41}) ? 5'b01000 : 5'b00000);
        end
        // bounce on channel 0: 1,0,1,1,0,1 then 0 -> nothing at all
        push(5'b00001, 5'b0, 5'b0, 5'b0);
        push(5'b00000, 5'b0, 5'b0, 5'b0);
        push(5'b00001, 5'b0, 5'b0, 5'b0);
        push(5'b00001, 5'b0, 5'b0, 5'b0);
        push(5'b00000, 5'b0, 5'b0, 5'b0);
        push(5'b00001, 5'b0, 5'b0, 5'b0);
        for (int i = 0; i < 10; i++) push(5'b00000, 5'b0, 5'b0, 5'b0);
        // release bounce on channel 2: high edges 1..20, blip high at 23,24
        for (int i = 0; i < 40; i++) begin
            e = i + 1;
            push((i < 20 || i == 22 || i == 23) ? 5'b00100 : 5'b00000,
                 (e >= 6 && e <= 29) ? 5'b00100 : 5'b00000,
                 (e == 6) ? 5'b00100 : 5'b00000,
                 (e inside {6, 16, 21}) ? 5'b00100 : 5'b00000);
        end
        // channels 1 and 2 together, high edges 1..8
        for (int i = 0; i < 20; i++) begin
            e = i + 1;
            push((i < 8) ? 5'b00110 : 5'b00000,
                 (e >= 6 && e <= 13) ? 5'b00110 : 5'b00000,
                 (e == 6) ? 5'b00110 : 5'b00000,
                 (e == 6) ? 5'b00110 : 5'b00000);
        end

        // reset state
        rst     = 1'b1;
        btn_raw = '0;
        raw2    = '0;
        @(negedge clk);
        step();
        step();
        check("rst_db", 0, btn_db, 5'b0);
        check("rst_scen", 0, btn_scen, 5'b0);
        check("rst_mcen", 0, btn_mcen, 5'b0);
        check("rst_db2", 0, db2, 5'b0);
        rst = 1'b0;

        // table-driven sequences
        for (int i = 0; i < vecs.size(); i++) begin
            btn_raw = vecs[i].raw;
            step();
            check("tbl_db", i, btn_db, vecs[i].db);
            check("tbl_scen", i, btn_scen, vecs[i].scen);
            check("tbl_mcen", i, btn_mcen, vecs[i].mcen);
        end

        // reset while channel 4 is held
        btn_raw = 5'b10000;
        for (int i = 0; i < 10; i++) step();
        check("hold_db", 0, btn_db, 5'b10000);
        rst = 1'b1;
        step();
        check("midrst_db", 0, btn_db, 5'b0);
        check("midrst_scen", 0, btn_scen, 5'b0);
        check("midrst_mcen", 0, btn_mcen, 5'b0);
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("rehold_scen", k, btn_scen, (k == 6) ? 5'b10000 : 5'b00000);
            check("rehold_db", k, btn_db, (k >= 6) ? 5'b10000 : 5'b00000);
        end
        btn_raw = '0;
        for (int i = 0; i < 8; i++) step();
        check("rehold_release_db", 0, btn_db, 5'b0);

        // repeat disabled: hold 100 cycles, expect one mcen coincident with scen
        n_scen = 0;
        n_mcen = 0;
        n_lone = 0;
        raw2   = 5'b00001;
        for (int i = 0; i < 120; i++) begin
            if (i == 100) raw2 = 5'b00000;
            step();
            if (scen2[0]) n_scen++;
            if (mcen2[0]) n_mcen++;
            if (mcen2[0] != scen2[0]) n_lone++;
        end
        check("norpt_scen_cnt", 0, 5'(n_scen), 5'd1);
        check("norpt_mcen_cnt", 0, 5'(n_mcen), 5'd1);
        check("norpt_lone_mcen", 0, 5'(n_lone), 5'd0);
        check("norpt_db_end", 0, db2, 5'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
